// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Wide adder built from one WIDTH-bit ripple-carry adder. An N = WIDTH*WORDS
//   bit addition is processed one chunk per cycle, least significant chunk
//   first. A carry register links each chunk to the next.
//
//   Optional feature macro: SIGNED_OVF_EN adds the ovf output, which flags
//   two's-complement overflow of the full N-bit result.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand set valid
//   in_ready   out  1  block idle and able to accept operands
//   a, b       in   N  operands
//   c_in       in   1  initial carry-in
//   out_valid  out  1  result valid; held until out_ready
//   out_ready  in   1  consumer accepts the result
//   sum        out  N  (a+b+c_in) mod 2^N
//   c_out      out  1  carry out of bit N-1
//   ovf        out  1  signed overflow (SIGNED_OVF_EN only)
module multiword_add_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   c_out
`ifdef SIGNED_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               out_valid_q, out_valid_d;
`ifdef SIGNED_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [31:0]        base;
  logic [WIDTH-1:0]   chunk_a;
  logic [WIDTH-1:0]   chunk_b;
  logic [WIDTH-1:0]   chunk_sum;
  logic               chunk_co;
  logic               rc;

  // Chunk adder: explicit ripple-carry over the currently selected chunk.
  always_comb begin
    base      = 32'(idx_q) * WIDTH;
    chunk_a   = a_q[base +: WIDTH];
    chunk_b   = b_q[base +: WIDTH];
    chunk_sum = '0;
    rc        = carry_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      chunk_sum[i] = chunk_a[i] ^ chunk_b[i] ^ rc;
      rc           = (chunk_a[i] & chunk_b[i]) | (rc & (chunk_a[i] ^ chunk_b[i]));
    end
    chunk_co = rc;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
`ifdef SIGNED_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[base +: WIDTH] = chunk_sum;
        carry_d              = chunk_co;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          c_out_d     = chunk_co;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = ST_DONE;
`ifdef SIGNED_OVF_EN
          // The final chunk supplies the result MSB, so test it directly.
          ovf_d = (a_q[N-1] == b_q[N-1]) && (chunk_sum[WIDTH-1] != a_q[N-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
`ifdef SIGNED_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq
//   Scoreboard bench for multiword_add_seq: a 4x4 (N=16) instance for the
//   sequencing, backpressure and reset cases, and a 4x1 instance swept
//   exhaustively. Define SIGNED_OVF_EN to also cover the ovf output.
module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, c_in, c_out;
  logic [15:0] a, b, sum;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1;
  logic [3:0]  a1, b1, sum1;
`ifdef SIGNED_OVF_EN
  logic        ovf, ovf1;
`endif

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.WIDTH(4), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out)
`ifdef SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  multiword_add_seq #(.WIDTH(4), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1)
`ifdef SIGNED_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  // One operation on the 16-bit instance; hold = cycles of out_ready=0 after out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input int hold);
    logic [16:0] full;
    exp_t        e;
    int          lat;
    wait_ready();
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    full = {1'b0, ta} + {1'b0, tb_v} + {16'b0, tc};
    e.s  = full[15:0];
    e.co = full[16];
    e.ov = (ta[15] == tb_v[15]) && (full[15] != ta[15]);
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = ~tc;
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd4);
    e = sb_q[0];
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'hAAAA; b = 16'h5555;
      tick();
      check_eq("hold_sum", 32'(sum), 32'(e.s));
      check_eq("hold_cout", 32'(c_out), 32'(e.co));
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = sb_q.pop_front();
    check_eq("sum", 32'(sum), 32'(e.s));
    check_eq("c_out", 32'(c_out), 32'(e.co));
`ifdef SIGNED_OVF_EN
    check_eq("ovf", 32'(ovf), 32'(e.ov));
`endif
    tick();
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [4:0] f;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; c_in1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_c_out", 32'(c_out), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SIGNED_OVF_EN
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 0);
    run_op(16'hBEEF, 16'h1357, 1'b1, 5);

    // Reset during the second RUN cycle discards the operation.
    wait_ready();
    a = 16'h1111; b = 16'h2222; c_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rr_in_ready", 32'(in_ready), 32'd1);
    check_eq("rr_out_valid", 32'(out_valid), 32'd0);
    check_eq("rr_sum", 32'(sum), 32'd0);
    check_eq("rr_c_out", 32'(c_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("rr_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0);

`ifdef SIGNED_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
`endif
    for (int k = 0; k < 6; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);

    // Exhaustive sweep on the single-chunk instance (out_ready1 held high).
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          for (int i = 0; i < 10 && !in_ready1; i++) tick();
          a1 = 4'(x); b1 = 4'(y); c_in1 = 1'(c); in_valid1 = 1'b1;
          f = {1'b0, a1} + {1'b0, b1} + {4'b0, c_in1};
          e.s  = {12'b0, f[3:0]};
          e.co = f[4];
          e.ov = (a1[3] == b1[3]) && (f[3] != a1[3]);
          sb_q.push_back(e);
          tick();
          in_valid1 = 1'b0;
          tick();
          check_eq("w1_latency", 32'(out_valid1), 32'd1);
          e = sb_q.pop_front();
          check_eq("w1_sum", {27'b0, c_out1, sum1}, {27'b0, e.co, e.s[3:0]});
`ifdef SIGNED_OVF_EN
          check_eq("w1_ovf", 32'(ovf1), 32'(e.ov));
`endif
        end
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
